// File: rtl/spiflash_pkg.sv
// Shared types and command codes for the SPI flash emulator.
package spiflash_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        ID,
        IGNORE
    } state_e;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
    localparam logic [7:0] CMD_JEDEC_ID  = 8'h9F;

endpackage

// File: rtl/spi_pin_sync.sv
// Brings the asynchronous SPI pins into the clk domain and finds SCLK edges.
module spi_pin_sync
    import spiflash_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic spi_cs_n,
    input  logic spi_sclk,
    input  logic spi_mosi,
    output logic cs_n_s,
    output logic mosi_s,
    output logic sclk_rise,
    output logic sclk_fall
);

    logic [1:0] cs_n_q, cs_n_d;
    logic [1:0] sclk_q, sclk_d;
    logic [1:0] mosi_q, mosi_d;
    logic       sclk_prev_q, sclk_prev_d;

    // Two-stage shift per pin; previous synced sclk kept for edge detection.
    always_comb begin
        cs_n_d      = {cs_n_q[0], spi_cs_n};
        sclk_d      = {sclk_q[0], spi_sclk};
        mosi_d      = {mosi_q[0], spi_mosi};
        sclk_prev_d = sclk_q[1];
    end

    // Synchronizer flops; cs_n resets deasserted so reset never looks like a select.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_n_q      <= 2'b11;
            sclk_q      <= 2'b00;
            mosi_q      <= 2'b00;
            sclk_prev_q <= 1'b0;
        end else begin
            cs_n_q      <= cs_n_d;
            sclk_q      <= sclk_d;
            mosi_q      <= mosi_d;
            sclk_prev_q <= sclk_prev_d;
        end
    end

    assign cs_n_s    = cs_n_q[1];
    assign mosi_s    = mosi_q[1];
    // Edges only count while the chip is selected.
    assign sclk_rise = ~cs_n_q[1] & sclk_q[1] & ~sclk_prev_q;
    assign sclk_fall = ~cs_n_q[1] & ~sclk_q[1] & sclk_prev_q;

endmodule

// File: rtl/spiflash_emu.sv
// SPI mode-0 flash slave: READ, FAST_READ and JEDEC ID served from a byte memory
// through a one-byte prefetch register. ADDR_BITS must lie in 9..24.
module spiflash_emu
    import spiflash_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = 21,
    parameter int unsigned DUMMY_BITS = 8,
    parameter logic [23:0] JEDEC_ID   = 24'hEF4018
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 spi_cs_n,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 mem_req,
    output logic [ADDR_BITS-1:0] mem_addr,
    input  logic                 mem_ack,
    input  logic [7:0]           mem_rdata,
    output logic                 underrun,
    output logic                 active
);

    localparam logic [7:0] DUMMY_LAST = 8'(DUMMY_BITS - 1);

    logic cs_n_s, mosi_s, sclk_rise, sclk_fall;

    spi_pin_sync u_sync (
        .clk       (clk),
        .reset     (reset),
        .spi_cs_n  (spi_cs_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .cs_n_s    (cs_n_s),
        .mosi_s    (mosi_s),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall)
    );

    state_e               state_q, state_d;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [6:0]           rx_q, rx_d;       // bit 8 of a byte arrives live on mosi_s
    logic [7:0]           tx_q, tx_d;
    logic                 load_pend_q, load_pend_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [1:0]           addr_cnt_q, addr_cnt_d;
    logic [7:0]           dummy_cnt_q, dummy_cnt_d;
    logic [1:0]           id_idx_q, id_idx_d;
    logic [ADDR_BITS-1:0] want_addr_q, want_addr_d; // next byte the prefetch must hold
    logic [ADDR_BITS-1:0] mem_addr_q, mem_addr_d;
    logic                 mem_req_q, mem_req_d;
    logic                 need_q, need_d;           // a fetch is owed but not yet issued
    logic                 stale_q, stale_d;         // outstanding fetch result is unwanted
    logic [7:0]           pf_data_q, pf_data_d;
    logic                 pf_valid_q, pf_valid_d;
    logic                 underrun_q, underrun_d;
    logic                 active_q, active_d;

    logic [7:0] rx_byte, id_byte;
    logic       byte_done, stale_new;

    assign rx_byte   = {rx_q, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    // Select the ID byte for the current position; zeros once the ID is exhausted.
    always_comb begin
        unique case (id_idx_q)
            2'd0:    id_byte = JEDEC_ID[23:16];
            2'd1:    id_byte = JEDEC_ID[15:8];
            2'd2:    id_byte = JEDEC_ID[7:0];
            default: id_byte = 8'h00;
        endcase
    end

    // Next-state: protocol FSM, shift registers, prefetch and memory handshake.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        load_pend_d = load_pend_q;
        cmd_d       = cmd_q;
        addr_cnt_d  = addr_cnt_q;
        dummy_cnt_d = dummy_cnt_q;
        id_idx_d    = id_idx_q;
        want_addr_d = want_addr_q;
        mem_addr_d  = mem_addr_q;
        mem_req_d   = mem_req_q;
        need_d      = need_q;
        stale_d     = stale_q;
        pf_data_d   = pf_data_q;
        pf_valid_d  = pf_valid_q;
        underrun_d  = underrun_q;
        active_d    = active_q;
        stale_new   = 1'b0;

        if (cs_n_s) begin
            state_d     = IDLE;
            bit_cnt_d   = 3'd0;
            rx_d        = 7'd0;
            tx_d        = 8'd0;
            load_pend_d = 1'b0;
            addr_cnt_d  = 2'd0;
            dummy_cnt_d = 8'd0;
            id_idx_d    = 2'd0;
            want_addr_d = '0;
            need_d      = 1'b0;
            pf_valid_d  = 1'b0;
            active_d    = 1'b0;
            stale_new   = mem_req_q;
        end else begin
            if (state_q == IDLE) begin
                state_d  = CMD;
                active_d = 1'b1;
            end
            if (sclk_rise) begin
                rx_d      = rx_byte[6:0];
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (byte_done) begin
                    load_pend_d = 1'b1;
                end
                unique case (state_q)
                    CMD: begin
                        if (byte_done) begin
                            cmd_d = rx_byte;
                            if (rx_byte == CMD_READ || rx_byte == CMD_FAST_READ) begin
                                state_d    = ADDR;
                                addr_cnt_d = 2'd0;
                            end else if (rx_byte == CMD_JEDEC_ID) begin
                                state_d  = ID;
                                id_idx_d = 2'd0;
                            end else begin
                                state_d  = IGNORE;
                                active_d = 1'b0;
                            end
                        end
                    end
                    ADDR: begin
                        if (byte_done) begin
                            // Accumulate straight into the fetch pointer; high bits fall off.
                            want_addr_d = {want_addr_q[ADDR_BITS-9:0], rx_byte};
                            addr_cnt_d  = addr_cnt_q + 2'd1;
                            if (addr_cnt_q == 2'd2) begin
                                need_d      = 1'b1;
                                pf_valid_d  = 1'b0;
                                stale_new   = mem_req_q;
                                dummy_cnt_d = 8'd0;
                                state_d     = (cmd_q == CMD_FAST_READ) ? DUMMY : DATA;
                            end
                        end
                    end
                    DUMMY: begin
                        dummy_cnt_d = dummy_cnt_q + 8'd1;
                        if (dummy_cnt_q == DUMMY_LAST) begin
                            // Realign byte framing so data starts on this fall.
                            state_d     = DATA;
                            load_pend_d = 1'b1;
                            bit_cnt_d   = 3'd0;
                        end
                    end
                    default: ;
                endcase
            end
            if (sclk_fall) begin
                if (load_pend_q) begin
                    load_pend_d = 1'b0;
                    unique case (state_q)
                        DATA: begin
                            tx_d        = pf_valid_q ? pf_data_q : 8'hFF;
                            underrun_d  = underrun_q | ~pf_valid_q;
                            pf_valid_d  = 1'b0;
                            want_addr_d = want_addr_q + 1'b1;
                            need_d      = 1'b1;
                            // A fetch still in flight was for the byte just sent.
                            stale_new   = mem_req_q;
                        end
                        ID: begin
                            tx_d = id_byte;
                            if (id_idx_q != 2'd3) begin
                                id_idx_d = id_idx_q + 2'd1;
                            end
                        end
                        default: tx_d = 8'h00;
                    endcase
                end else begin
                    tx_d = {tx_q[6:0], 1'b0};
                end
            end
        end

        if (mem_req_q && mem_ack) begin
            mem_req_d = 1'b0;
            if (!(stale_q || stale_new)) begin
                pf_data_d  = mem_rdata;
                pf_valid_d = 1'b1;
            end
            stale_d = 1'b0;
        end else if (stale_new) begin
            stale_d = 1'b1;
        end

        // Requests never overlap: a new one waits until the previous is acked.
        if (need_d && !mem_req_q) begin
            mem_req_d  = 1'b1;
            mem_addr_d = want_addr_d;
            need_d     = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 3'd0;
            rx_q        <= 7'd0;
            tx_q        <= 8'd0;
            load_pend_q <= 1'b0;
            cmd_q       <= 8'd0;
            addr_cnt_q  <= 2'd0;
            dummy_cnt_q <= 8'd0;
            id_idx_q    <= 2'd0;
            want_addr_q <= '0;
            mem_addr_q  <= '0;
            mem_req_q   <= 1'b0;
            need_q      <= 1'b0;
            stale_q     <= 1'b0;
            pf_data_q   <= 8'd0;
            pf_valid_q  <= 1'b0;
            underrun_q  <= 1'b0;
            active_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            load_pend_q <= load_pend_d;
            cmd_q       <= cmd_d;
            addr_cnt_q  <= addr_cnt_d;
            dummy_cnt_q <= dummy_cnt_d;
            id_idx_q    <= id_idx_d;
            want_addr_q <= want_addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_req_q   <= mem_req_d;
            need_q      <= need_d;
            stale_q     <= stale_d;
            pf_data_q   <= pf_data_d;
            pf_valid_q  <= pf_valid_d;
            underrun_q  <= underrun_d;
            active_q    <= active_d;
        end
    end

    assign spi_miso = tx_q[7];
    assign mem_req  = mem_req_q;
    assign mem_addr = mem_addr_q;
    assign underrun = underrun_q;
    assign active   = active_q;

endmodule

// File: tb/tb_spiflash_emu.sv
// Self-checking bench for spiflash_emu: SPI master tasks, latency-configurable memory,
// and a byte-level reference model of what each transaction must return.
module tb_spiflash_emu;

    localparam int unsigned ADDR_BITS = 21;
    localparam int          HALF      = 8;    // SCLK = clk/16
    localparam int          GAP       = 100;
    localparam logic [23:0] JEDEC     = 24'hEF4018;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 spi_cs_n, spi_sclk, spi_mosi, spi_miso;
    logic                 mem_req, mem_ack, underrun, active;
    logic [ADDR_BITS-1:0] mem_addr;
    logic [7:0]           mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;

    int                   mem_lat = 1;
    logic [7:0]           mem_key = 8'h00;
    logic [ADDR_BITS-1:0] req_log[$];
    logic [7:0]           got_q[$];
    bit                   no_req_expected = 1'b0;
    bit                   miso_quiet = 1'b0;

    always #5 clk = ~clk;

    spiflash_emu #(
        .ADDR_BITS  (ADDR_BITS),
        .DUMMY_BITS (8),
        .JEDEC_ID   (JEDEC)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .spi_cs_n  (spi_cs_n),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .underrun  (underrun),
        .active    (active)
    );

    function automatic logic [7:0] mem_byte(input logic [ADDR_BITS-1:0] a);
        return a[7:0] ^ mem_key;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory: one request at a time, ack after mem_lat cycles, log every address.
    logic [ADDR_BITS-1:0] ma;
    initial begin
        mem_ack   = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1) begin
                ma = mem_addr;
                req_log.push_back(ma);
                repeat (mem_lat) @(negedge clk);
                mem_rdata = mem_byte(ma);
                mem_ack   = 1'b1;
                @(negedge clk);
                mem_ack   = 1'b0;
            end
        end
    end

    // Per-cycle interface checks.
    logic                 prev_req;
    logic [ADDR_BITS-1:0] prev_addr;
    always @(negedge clk) begin
        if (reset === 1'b0 && mem_req === 1'b1 && prev_req === 1'b1)
            check("mem_addr_stable", 32'(mem_addr), 32'(prev_addr));
        if (no_req_expected) check("no_mem_req", 32'(mem_req), 32'd0);
        if (miso_quiet) check("miso_quiet", 32'(spi_miso), 32'd0);
        prev_req  <= mem_req;
        prev_addr <= mem_addr;
    end

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        repeat (HALF) @(negedge clk);
        spi_sclk = 1'b1;
        r = spi_miso;
        repeat (HALF) @(negedge clk);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b, output logic [7:0] r);
        logic rb;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(b[i], rb);
            r[i] = rb;
        end
    endtask

    task automatic do_xact(input logic [7:0] cmd, input logic [23:0] addr, input int nd);
        logic [7:0] r;
        logic       known;
        logic       is_rd;
        got_q.delete();
        req_log.delete();
        known = (cmd == 8'h03 || cmd == 8'h0B || cmd == 8'h9F);
        is_rd = (cmd == 8'h03 || cmd == 8'h0B);
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        check("active_cs_low", 32'(active), 32'd1);
        spi_byte(cmd, r);
        check("active_after_cmd", 32'(active), 32'(known));
        if (is_rd) begin
            for (int i = 2; i >= 0; i--) spi_byte(addr[8*i +: 8], r);
        end
        if (cmd == 8'h0B) spi_byte(8'h00, r);
        for (int i = 0; i < nd; i++) begin
            spi_byte(8'h00, r);
            got_q.push_back(r);
        end
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (GAP) @(negedge clk);
    endtask

    // Reference: byte i of a read is memory at (addr + i) mod 2^ADDR_BITS.
    task automatic check_read(input logic [23:0] addr, input int nd);
        logic [ADDR_BITS-1:0] a;
        for (int i = 0; i < nd; i++) begin
            a = addr[ADDR_BITS-1:0] + ADDR_BITS'(i);
            check($sformatf("rd_byte%0d", i), 32'(got_q[i]), 32'(mem_byte(a)));
        end
        if (req_log.size() == 0) check("first_req_missing", 32'd0, 32'd1);
        else check("first_req_addr", 32'(req_log[0]), 32'(addr[ADDR_BITS-1:0]));
    endtask

    task automatic check_id(input int nd);
        logic [23:0] j;
        logic [7:0]  e;
        j = JEDEC;
        for (int i = 0; i < nd; i++) begin
            e = (i < 3) ? j[8*(2-i) +: 8] : 8'h00;
            check($sformatf("id_byte%0d", i), 32'(got_q[i]), 32'(e));
        end
    endtask

    initial begin
        logic [7:0]  r;
        logic        rb;
        int          kind;
        int          nd;
        logic [23:0] a;

        reset    = 1'b1;
        spi_cs_n = 1'b1;
        spi_sclk = 1'b0;
        spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        check("rst_miso", 32'(spi_miso), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_active", 32'(active), 32'd0);
        repeat (10) @(negedge clk);

        // Plain read, short latency.
        mem_lat = 1;
        do_xact(8'h03, 24'h000010, 4);
        check("rd10_b0", 32'(got_q[0]), 32'h10);
        check("rd10_b1", 32'(got_q[1]), 32'h11);
        check("rd10_b2", 32'(got_q[2]), 32'h12);
        check("rd10_b3", 32'(got_q[3]), 32'h13);
        check("rd10_underrun", 32'(underrun), 32'd0);

        // Fast read hides a 20-cycle latency.
        mem_lat = 20;
        do_xact(8'h0B, 24'h000100, 2);
        check("fr_b0", 32'(got_q[0]), 32'h00);
        check("fr_b1", 32'(got_q[1]), 32'h01);
        check("fr_underrun", 32'(underrun), 32'd0);

        // JEDEC ID.
        mem_lat = 1;
        no_req_expected = 1'b1;
        do_xact(8'h9F, 24'h0, 5);
        no_req_expected = 1'b0;
        check("id_b0", 32'(got_q[0]), 32'hEF);
        check("id_b1", 32'(got_q[1]), 32'h40);
        check("id_b2", 32'(got_q[2]), 32'h18);
        check("id_b3", 32'(got_q[3]), 32'h00);
        check("id_b4", 32'(got_q[4]), 32'h00);
        check("id_no_req", 32'(req_log.size()), 32'd0);

        // Address wrap at the top of a 21-bit space.
        do_xact(8'h03, 24'h1FFFFE, 4);
        check("wrap_b0", 32'(got_q[0]), 32'hFE);
        check("wrap_b3", 32'(got_q[3]), 32'h01);
        if (req_log.size() < 4) check("wrap_req_count", 32'(req_log.size()), 32'd4);
        else begin
            check("wrap_a0", 32'(req_log[0]), 32'h1FFFFE);
            check("wrap_a1", 32'(req_log[1]), 32'h1FFFFF);
            check("wrap_a2", 32'(req_log[2]), 32'h000000);
            check("wrap_a3", 32'(req_log[3]), 32'h000001);
        end

        // Unknown command is ignored.
        miso_quiet = 1'b1;
        no_req_expected = 1'b1;
        do_xact(8'hAB, 24'h0, 3);
        miso_quiet = 1'b0;
        no_req_expected = 1'b0;
        for (int i = 0; i < 3; i++) check("ign_byte", 32'(got_q[i]), 32'd0);

        // CS abort mid address, then a clean read.
        req_log.delete();
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        for (int i = 0; i < 4; i++) spi_bit(1'b1, rb);
        repeat (HALF) @(negedge clk);
        spi_cs_n = 1'b1;
        repeat (GAP) @(negedge clk);
        check("abort_no_req", 32'(req_log.size()), 32'd0);
        do_xact(8'h03, 24'h000020, 1);
        check("abort_then_rd", 32'(got_q[0]), 32'h20);

        // Randomized transactions against the model.
        for (int t = 0; t < 12; t++) begin
            kind    = $urandom_range(0, 2);
            a       = 24'($urandom);
            nd      = $urandom_range(1, 5);
            mem_key = 8'($urandom);
            if (kind == 0) begin
                mem_lat = $urandom_range(1, 4);
                do_xact(8'h03, a, nd);
                check_read(a, nd);
            end else if (kind == 1) begin
                mem_lat = $urandom_range(1, 60);
                do_xact(8'h0B, a, nd);
                check_read(a, nd);
            end else begin
                no_req_expected = 1'b1;
                do_xact(8'h9F, a, nd);
                no_req_expected = 1'b0;
                check_id(nd);
            end
            check("rand_underrun", 32'(underrun), 32'd0);
        end
        mem_key = 8'h00;

        // Plain read with too much latency: first byte underruns, address still advances.
        mem_lat = 20;
        do_xact(8'h03, 24'h000200, 3);
        check("ur_b0", 32'(got_q[0]), 32'hFF);
        check("ur_b1", 32'(got_q[1]), 32'h01);
        check("ur_b2", 32'(got_q[2]), 32'h02);
        check("ur_flag", 32'(underrun), 32'd1);
        mem_lat = 1;
        do_xact(8'h03, 24'h000030, 1);
        check("ur_next_b0", 32'(got_q[0]), 32'h30);
        check("ur_sticky", 32'(underrun), 32'd1);

        // Reset in the middle of a data byte.
        spi_cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
        spi_byte(8'h03, r);
        spi_byte(8'h00, r);
        spi_byte(8'h00, r);
        spi_byte(8'h40, r);
        spi_byte(8'h00, r);
        check("pre_rst_b0", 32'(r), 32'h40);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, rb);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_miso", 32'(spi_miso), 32'd0);
        check("mid_rst_mem_req", 32'(mem_req), 32'd0);
        check("mid_rst_mem_addr", 32'(mem_addr), 32'd0);
        check("mid_rst_underrun", 32'(underrun), 32'd0);
        check("mid_rst_active", 32'(active), 32'd0);
        spi_cs_n = 1'b1;
        repeat (GAP) @(negedge clk);
        do_xact(8'h03, 24'h000055, 2);
        check("post_rst_b0", 32'(got_q[0]), 32'h55);
        check("post_rst_b1", 32'(got_q[1]), 32'h56);
        check("post_rst_underrun", 32'(underrun), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
